// File: rtl/shreg_pkg.sv
// Shared definitions for the shift/rotate sequencer: op codes, FSM encoding
// and small width-independent helpers.
package shreg_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam logic [2:0] OP_SLS = 3'b101;
    localparam logic [2:0] OP_SRS = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // A request with nothing to do skips SHIFT and just pulses done.
    function automatic logic is_noop(input logic [2:0] op, input logic amt_zero);
        return amt_zero || (op == OP_RSV);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step; bit_out is the bit that leaves
// the register (MSB for left moves, bit 0 for right moves).
module shift_step
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic             sin,
    output logic [WIDTH-1:0] q_next,
    output logic             bit_out
);

    always_comb begin
        q_next  = q;
        bit_out = 1'b0;
        case (op)
            OP_SLL: begin
                q_next  = {q[WIDTH-2:0], 1'b0};
                bit_out = q[WIDTH-1];
            end
            OP_SRL: begin
                q_next  = {1'b0, q[WIDTH-1:1]};
                bit_out = q[0];
            end
            OP_SRA: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                bit_out = q[0];
            end
            OP_ROL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                bit_out = q[WIDTH-1];
            end
            OP_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                bit_out = q[0];
            end
            OP_SLS: begin
                q_next  = {q[WIDTH-2:0], sin};
                bit_out = q[WIDTH-1];
            end
            OP_SRS: begin
                q_next  = {sin, q[WIDTH-1:1]};
                bit_out = q[0];
            end
            default: begin
                q_next  = q;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shreg_seq.sv
// Loadable WIDTH-bit register with a multi-cycle shift/rotate sequencer that
// moves one bit per clock, with start/busy/done handshaking and serial I/O.
module shreg_seq
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             clrn_i,
    input  logic             wen_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sout_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t           state_reg;
    logic [AMT_W-1:0] cnt_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] q_reg;
    logic             sout_reg;

    logic [WIDTH-1:0] step_q;
    logic             step_bit;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .q      (q_reg),
        .op     (op_reg),
        .sin    (sin_i),
        .q_next (step_q),
        .bit_out(step_bit)
    );

    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= OP_SLL;
            q_reg     <= '0;
            sout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // A same-edge load lands in q_reg first, so the shifts
                    // starting next edge operate on the loaded value.
                    if (wen_i) begin
                        q_reg <= d_i;
                    end
                    if (start_i) begin
                        op_reg    <= op_i;
                        cnt_reg   <= amt_i;
                        state_reg <= is_noop(op_i, amt_i == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    q_reg    <= step_q;
                    sout_reg <= step_bit;
                    cnt_reg  <= cnt_reg - 1'b1;
                    if (cnt_reg == AMT_W'(1)) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign q_o    = q_reg;
    assign sout_o = sout_reg;
    assign busy_o = (state_reg != ST_IDLE);
    assign done_o = (state_reg == ST_DONE);

endmodule

// File: tb/tb_shreg_seq.sv
// Self-checking bench for shreg_seq: directed scenarios plus randomized
// sequences checked against a whole-sequence arithmetic reference model.
module tb_shreg_seq;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    logic             clk_i   = 1'b0;
    logic             clrn_i  = 1'b0;
    logic             wen_i   = 1'b0;
    logic [WIDTH-1:0] d_i     = '0;
    logic             start_i = 1'b0;
    logic [2:0]       op_i    = '0;
    logic [AMT_W-1:0] amt_i   = '0;
    logic             sin_i   = 1'b0;
    logic [WIDTH-1:0] q_o;
    logic             sout_o;
    logic             busy_o;
    logic             done_o;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int unsigned exp_q    = 0;
    logic        exp_sout = 1'b0;

    shreg_seq #(
        .WIDTH(WIDTH)
    ) dut (
        .clk_i  (clk_i),
        .clrn_i (clrn_i),
        .wen_i  (wen_i),
        .d_i    (d_i),
        .start_i(start_i),
        .op_i   (op_i),
        .amt_i  (amt_i),
        .sin_i  (sin_i),
        .q_o    (q_o),
        .sout_o (sout_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Whole-sequence result of shifting exp_q by k places; s[j] is the serial
    // bit presented on the j-th shift cycle.
    function automatic void model_seq(input int op, input int k, input logic [15:0] s);
        int unsigned q   = exp_q;
        int unsigned ins = 0;
        if (k == 0 || op == 7) return;
        case (op)
            0: begin exp_q = (q << k) & 255;                    exp_sout = 1'((q >> (8 - k)) & 1); end
            1: begin exp_q = q >> k;                            exp_sout = 1'((q >> (k - 1)) & 1); end
            2: begin
                exp_sout = 1'((q >> (k - 1)) & 1);
                if ((q & 128) != 0) q = q | 32'hFFFF_FF00;
                exp_q = (q >> k) & 255;
            end
            3: begin exp_q = ((q << k) | (q >> (8 - k))) & 255; exp_sout = 1'((q >> (8 - k)) & 1); end
            4: begin exp_q = ((q >> k) | (q << (8 - k))) & 255; exp_sout = 1'((q >> (k - 1)) & 1); end
            5: begin
                for (int j = 0; j < k; j++) if (s[j]) ins = ins | (1 << (k - 1 - j));
                exp_q = ((q << k) & 255) | ins;
                exp_sout = 1'((q >> (8 - k)) & 1);
            end
            default: begin
                for (int j = 0; j < k; j++) if (s[j]) ins = ins | (1 << (8 - k + j));
                exp_q = (q >> k) | ins;
                exp_sout = 1'((q >> (k - 1)) & 1);
            end
        endcase
    endfunction

    task automatic do_load(input logic [7:0] v);
        wen_i = 1'b1;
        d_i   = v;
        @(posedge clk_i); #1;
        wen_i = 1'b0;
        exp_q = v;
        check("load_q", q_o, exp_q);
        check("load_busy", busy_o, 1'b0);
        $display("load d=%02h -> q=%02h", v, q_o);
    endtask

    task automatic run_seq(input string tag, input int op, input int k, input logic [15:0] s,
                           input bit with_load, input logic [7:0] ldv, input bit poke);
        int c        = 0;
        int busy_n   = 0;
        int done_n   = 0;
        int done_pos = -1;
        int eff_k    = (op == 7) ? 0 : k;
        if (with_load) exp_q = ldv;
        model_seq(op, k, s);
        start_i = 1'b1;
        op_i    = op[2:0];
        amt_i   = k[2:0];
        wen_i   = with_load;
        d_i     = ldv;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        wen_i   = 1'b0;
        while (busy_o && c < 3 * WIDTH) begin
            busy_n++;
            if (done_o) begin
                done_n++;
                done_pos = c;
            end
            sin_i = s[c % 16];
            if (poke) begin
                wen_i   = 1'b1;
                d_i     = 8'($urandom);
                start_i = 1'b1;
                op_i    = 3'($urandom);
                amt_i   = 3'($urandom);
            end
            @(posedge clk_i); #1;
            c++;
        end
        wen_i   = 1'b0;
        start_i = 1'b0;
        sin_i   = 1'b0;
        check({tag, "_busy_cycles"}, busy_n, eff_k + 1);
        check({tag, "_done_count"}, done_n, 1);
        check({tag, "_done_pos"}, done_pos, eff_k);
        check({tag, "_q"}, q_o, exp_q);
        check({tag, "_sout"}, sout_o, exp_sout);
        check({tag, "_idle_done"}, done_o, 1'b0);
        $display("seq %s op=%0d amt=%0d load=%0d poke=%0d -> q=%02h sout=%0d busy_cycles=%0d",
                 tag, op, k, with_load, poke, q_o, sout_o, busy_n);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_q", q_o, 8'h00);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_sout", sout_o, 1'b0);
        clrn_i = 1'b1;

        do_load(8'hA5);

        do_load(8'h96);
        run_seq("sra3", 2, 3, 16'h0000, 1'b0, 8'h00, 1'b0);
        check("sra3_val", q_o, 8'hF2);

        do_load(8'h3C);
        run_seq("rol4", 3, 4, 16'h0000, 1'b0, 8'h00, 1'b0);
        check("rol4_val", q_o, 8'hC3);
        run_seq("ror4", 4, 4, 16'h0000, 1'b0, 8'h00, 1'b0);
        check("ror4_val", q_o, 8'h3C);

        do_load(8'h00);
        run_seq("sls5", 5, 5, 16'b01101, 1'b0, 8'h00, 1'b0);
        check("sls5_val", q_o, 8'h16);

        run_seq("ld_srl1", 1, 1, 16'h0000, 1'b1, 8'h81, 1'b0);
        check("ld_srl1_val", q_o, 8'h40);

        run_seq("poke_sll3", 0, 3, 16'h0000, 1'b0, 8'h00, 1'b1);
        run_seq("amt0", 3, 0, 16'h0000, 1'b0, 8'h00, 1'b0);
        run_seq("op7", 7, 5, 16'h0000, 1'b0, 8'h00, 1'b0);
        run_seq("srs7", 6, 7, 16'h0055, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a shift sequence
        do_load(8'h5A);
        start_i = 1'b1;
        op_i    = 3'd0;
        amt_i   = 3'd6;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        check("mid_busy_before", busy_o, 1'b1);
        #2;
        clrn_i = 1'b0;
        #1;
        check("mid_rst_q", q_o, 8'h00);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_sout", sout_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            check("mid_rst_no_done", done_o, 1'b0);
        end
        clrn_i   = 1'b1;
        exp_q    = 0;
        exp_sout = 1'b0;
        run_seq("post_rst_rol3", 3, 3, 16'h0000, 1'b1, 8'hB1, 1'b0);

        // Randomized sequences
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) do_load(8'($urandom));
            run_seq("rnd", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    16'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
